// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a single-outstanding request/ready
// handshake to instruction memory and fills the IF/ID slot through a one-entry skid.
module if_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(3'd4);

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] drain_addr_r;
    logic [ADDR_W-1:0] skid_pc_r;
    logic [DATA_W-1:0] skid_instr_r;

    logic              redir_s;
    logic              cons_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_next_s;

    assign redir_s     = (pc_src != 2'b00);
    assign cons_s      = if_valid & ~stall;
    assign pc_next_s   = pc_r + PC_INC;
    assign if_pc_plus4 = if_pc + PC_INC;

    // Redirect target selection
    always_comb begin
        target_s = pc_r;
        case (pc_src)
            2'b01:   target_s = branch_target;
            2'b10:   target_s = jump_target;
            2'b11:   target_s = jr_target;
            default: target_s = pc_r;
        endcase
    end

    // Fetch FSM with registered request/address and IF/ID slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            drain_addr_r <= {ADDR_W{1'b0}};
            skid_pc_r    <= {ADDR_W{1'b0}};
            skid_instr_r <= {DATA_W{1'b0}};
            imem_req     <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            if_valid     <= 1'b0;
            if_pc        <= {ADDR_W{1'b0}};
            if_instr     <= {DATA_W{1'b0}};
        end else if (redir_s) begin
            // Redirect beats stall and any same-cycle response
            pc_r         <= target_s;
            if_valid     <= 1'b0;
            skid_pc_r    <= {ADDR_W{1'b0}};
            skid_instr_r <= {DATA_W{1'b0}};
            case (state_r)
                FETCH: begin
                    if (imem_ready) begin
                        state_r   <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= target_s;
                    end else begin
                        state_r      <= DRAIN;
                        drain_addr_r <= pc_r;
                        imem_req     <= 1'b1;
                        imem_addr    <= pc_r;
                    end
                end
                DRAIN: begin
                    // A completing drain needs no further wait; otherwise keep draining
                    if (imem_ready) begin
                        state_r   <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= target_s;
                    end else begin
                        state_r   <= DRAIN;
                        imem_req  <= 1'b1;
                        imem_addr <= drain_addr_r;
                    end
                end
                default: begin
                    state_r   <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= target_s;
                end
            endcase
        end else begin
            if (cons_s) begin
                if_valid <= 1'b0;
            end else begin
                if_valid <= if_valid;
            end
            case (state_r)
                IDLE: begin
                    state_r   <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_r;
                end
                FETCH: begin
                    if (imem_ready && (!if_valid || cons_s)) begin
                        if_valid  <= 1'b1;
                        if_pc     <= pc_r;
                        if_instr  <= imem_rdata;
                        pc_r      <= pc_next_s;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_next_s;
                    end else if (imem_ready) begin
                        skid_pc_r    <= pc_r;
                        skid_instr_r <= imem_rdata;
                        pc_r         <= pc_next_s;
                        state_r      <= HOLD;
                        imem_req     <= 1'b0;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc_r;
                    end
                end
                HOLD: begin
                    if (cons_s) begin
                        if_valid     <= 1'b1;
                        if_pc        <= skid_pc_r;
                        if_instr     <= skid_instr_r;
                        skid_pc_r    <= {ADDR_W{1'b0}};
                        skid_instr_r <= {DATA_W{1'b0}};
                        state_r      <= FETCH;
                        imem_req     <= 1'b1;
                        imem_addr    <= pc_r;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state_r   <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_r;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= drain_addr_r;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: streaming, stall/skid, drain, redirect flush,
// asynchronous reset mid-drain and PC wrap-around.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    int checks_r;
    int failures_r;

    if_fetch_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_3000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_pc_plus4  (if_pc_plus4)
    );

    // Memory model: instruction word is a fixed scramble of its address
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_r      = 0;
        failures_r    = 0;
        reset         = 1'b0;
        pc_src        = 2'b00;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        jr_target     = 32'h0;
        stall         = 1'b0;
        imem_ready    = 1'b1;
        #2;
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_pc",    if_pc,             32'h0);
        check_eq("rst_instr", if_instr,          32'h0);
        tick();
        tick();
        reset = 1'b1;
        check_eq("idle_req", {31'd0, imem_req}, 32'd0);

        // Streaming at one instruction per cycle
        tick();
        check_eq("f0_req",  {31'd0, imem_req}, 32'd1);
        check_eq("f0_addr", imem_addr,         32'h3000);
        check_eq("f0_vld",  {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("f1_addr",  imem_addr,         32'h3004);
        check_eq("f1_vld",   {31'd0, if_valid}, 32'd1);
        check_eq("f1_pc",    if_pc,             32'h3000);
        check_eq("f1_pc4",   if_pc_plus4,       32'h3004);
        check_eq("f1_instr", if_instr,          word_at(32'h3000));
        tick();
        check_eq("f2_addr", imem_addr, 32'h3008);
        check_eq("f2_pc",   if_pc,     32'h3004);

        // Stall three cycles: 0x3008 goes to the skid, no requests in HOLD
        stall = 1'b1;
        tick();
        check_eq("h0_req", {31'd0, imem_req}, 32'd0);
        check_eq("h0_pc",  if_pc,             32'h3004);
        check_eq("h0_vld", {31'd0, if_valid}, 32'd1);
        tick();
        check_eq("h1_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("h2_pc",  if_pc,             32'h3004);
        stall = 1'b0;
        tick();
        check_eq("s0_pc",    if_pc,             32'h3008);
        check_eq("s0_instr", if_instr,          word_at(32'h3008));
        check_eq("s0_req",   {31'd0, imem_req}, 32'd1);
        check_eq("s0_addr",  imem_addr,         32'h300C);
        tick();
        check_eq("s1_pc",   if_pc,     32'h300C);
        check_eq("s1_addr", imem_addr, 32'h3010);

        // Branch while the 0x3010 request waits: drain then refetch at target
        imem_ready = 1'b0;
        tick();
        check_eq("w0_vld",  {31'd0, if_valid}, 32'd0);
        check_eq("w0_addr", imem_addr,         32'h3010);
        pc_src        = 2'b01;
        branch_target = 32'h3100;
        tick();
        pc_src = 2'b00;
        check_eq("d0_req",  {31'd0, imem_req}, 32'd1);
        check_eq("d0_addr", imem_addr,         32'h3010);
        check_eq("d0_vld",  {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("d1_addr", imem_addr, 32'h3010);
        imem_ready = 1'b1;
        tick();
        check_eq("d2_addr", imem_addr,         32'h3100);
        check_eq("d2_vld",  {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("b0_vld",  {31'd0, if_valid}, 32'd1);
        check_eq("b0_pc",   if_pc,             32'h3100);
        check_eq("b0_addr", imem_addr,         32'h3104);

        // jr with response and stall in the same cycle: flush and refetch
        stall     = 1'b1;
        pc_src    = 2'b11;
        jr_target = 32'h3200;
        tick();
        pc_src = 2'b00;
        stall  = 1'b0;
        check_eq("j0_vld",  {31'd0, if_valid}, 32'd0);
        check_eq("j0_addr", imem_addr,         32'h3200);
        tick();
        check_eq("j1_pc",    if_pc,    32'h3200);
        check_eq("j1_instr", if_instr, word_at(32'h3200));

        // Enter DRAIN, then assert reset between edges
        imem_ready  = 1'b0;
        stall       = 1'b1;
        tick();
        pc_src      = 2'b10;
        jump_target = 32'h4000;
        tick();
        pc_src = 2'b00;
        check_eq("r0_req",  {31'd0, imem_req}, 32'd1);
        check_eq("r0_addr", imem_addr,         32'h3204);
        #2;
        reset = 1'b0;
        #1;
        check_eq("r1_req", {31'd0, imem_req}, 32'd0);
        check_eq("r1_vld", {31'd0, if_valid}, 32'd0);
        tick();
        reset      = 1'b1;
        stall      = 1'b0;
        imem_ready = 1'b1;
        check_eq("r2_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("r3_addr", imem_addr, 32'h3000);

        // Jump to the top of the address space and wrap
        pc_src      = 2'b10;
        jump_target = 32'hFFFF_FFFC;
        tick();
        pc_src = 2'b00;
        check_eq("x0_addr", imem_addr,         32'hFFFF_FFFC);
        check_eq("x0_vld",  {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("x1_addr", imem_addr,   32'h0000_0000);
        check_eq("x1_pc",   if_pc,       32'hFFFF_FFFC);
        check_eq("x1_pc4",  if_pc_plus4, 32'h0000_0000);
        tick();
        check_eq("x2_pc",   if_pc,     32'h0000_0000);
        check_eq("x2_addr", imem_addr, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
